// File: rtl/baud_pkg.sv
// Shared definitions for the UART baud tick generator: the rate table,
// the rate-code enumeration and the divider rounding helper.
package baud_pkg;

  localparam int RATE_W    = 3;
  localparam int NUM_RATES = 8;

  typedef enum logic [RATE_W-1:0] {
    RATE_300    = 3'd0,
    RATE_1200   = 3'd1,
    RATE_4800   = 3'd2,
    RATE_9600   = 3'd3,
    RATE_19200  = 3'd4,
    RATE_38400  = 3'd5,
    RATE_57600  = 3'd6,
    RATE_115200 = 3'd7
  } rate_e;

  localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Nearest-integer clocks per oversample tick; 64-bit so large clocks never overflow.
  function automatic longint unsigned div_round(input int unsigned clk_hz,
                                                input int unsigned baud,
                                                input int unsigned oversample);
    longint unsigned den;
    den = 64'(baud) * 64'(oversample);
    return (64'(clk_hz) + den / 64'd2) / den;
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control and strobe bundle between the baud generator and its UART user.
interface baud_tick_gen_if;
  import baud_pkg::*;

  logic              enable;
  logic [RATE_W-1:0] baud_select;
  logic              rx_resync;
  logic              rx_tick;
  logic              rx_bit;
  logic              tx_tick;
  logic [RATE_W-1:0] sel_active;

  modport master (
    output enable, baud_select, rx_resync,
    input  rx_tick, rx_bit, tx_tick, sel_active
  );

  modport slave (
    input  enable, baud_select, rx_resync,
    output rx_tick, rx_bit, tx_tick, sel_active
  );

endinterface

// File: rtl/baud_phase_cnt.sv
// Modulo-MOD phase counter: advances once per oversample tick and emits a
// registered one-cycle strobe on the tick where the count equals MATCH.
module baud_phase_cnt #(
  parameter int unsigned MOD   = 16,
  parameter int unsigned MATCH = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic match
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

  logic [W-1:0] cnt;

  // Clear wins over advance so a resync landing on a tick suppresses that strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      match <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      match <= 1'b0;
    end else if (advance) begin
      match <= (cnt == W'(MATCH));
      cnt   <= (cnt == W'(MOD - 1)) ? '0 : cnt + 1'b1;
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: divides clk to an oversample strobe and derives the
// receiver bit-centre and transmitter bit-period strobes from it.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  baud_tick_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] RESET_RELOAD =
    CNT_W'(div_round(CLK_HZ, BAUD_TABLE[RATE_300], OVERSAMPLE) - 64'd1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
  end

  logic [CNT_W-1:0] div_m1 [NUM_RATES];

  for (genvar s = 0; s < NUM_RATES; s++) begin : g_div
    localparam longint unsigned DIV_S = div_round(CLK_HZ, BAUD_TABLE[s], OVERSAMPLE);
    if (DIV_S < 64'd1 || DIV_S >= (64'd1 << CNT_W)) begin : g_bad_div
      $error("baud_tick_gen: divider for rate code %0d does not fit CNT_W", s);
    end
    assign div_m1[s] = CNT_W'(DIV_S - 64'd1);
  end

  logic [CNT_W-1:0] div_cnt;
  rate_e            sel_q;
  logic             rx_tick_q;
  logic             tick_now;

  assign tick_now = bus.enable && (div_cnt == '0);

  // Rate changes are only accepted at a reload (or while held), so a period
  // is never cut short by a mid-count baud_select change.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= RESET_RELOAD;
      sel_q     <= RATE_300;
      rx_tick_q <= 1'b0;
    end else if (!bus.enable) begin
      sel_q     <= rate_e'(bus.baud_select);
      div_cnt   <= div_m1[bus.baud_select];
      rx_tick_q <= 1'b0;
    end else if (div_cnt == '0) begin
      sel_q     <= rate_e'(bus.baud_select);
      div_cnt   <= div_m1[bus.baud_select];
      rx_tick_q <= 1'b1;
    end else begin
      div_cnt   <= div_cnt - 1'b1;
      rx_tick_q <= 1'b0;
    end
  end

  logic tx_match;
  logic rx_match;

  baud_phase_cnt #(
    .MOD   (OVERSAMPLE),
    .MATCH (OVERSAMPLE - 1)
  ) u_tx_phase (
    .clk     (clk),
    .reset   (reset),
    .clear   (!bus.enable),
    .advance (tick_now),
    .match   (tx_match)
  );

  baud_phase_cnt #(
    .MOD   (OVERSAMPLE),
    .MATCH (OVERSAMPLE / 2 - 1)
  ) u_rx_phase (
    .clk     (clk),
    .reset   (reset),
    .clear   (!bus.enable || bus.rx_resync),
    .advance (tick_now),
    .match   (rx_match)
  );

  assign bus.rx_tick    = rx_tick_q;
  assign bus.rx_bit     = rx_match;
  assign bus.tx_tick    = tx_match;
  assign bus.sel_active = sel_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at CLK_HZ=1_843_200 (DIV = 384..1): expected
// strobe cycles are queued as stimulus is applied and matched at each negedge.
module tb_baud_tick_gen;

  logic clk = 1'b0;
  logic reset;

  baud_tick_gen_if bus ();

  baud_tick_gen #(
    .CLK_HZ     (1_843_200),
    .OVERSAMPLE (16),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int q_rx  [$];
  int q_bit [$];
  int q_tx  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Compare one strobe against the head of its scoreboard queue.
  task automatic mon_one(input string tag, input logic obs, input int qsize,
                         input int head, output bit pop);
    bit exp_now;
    exp_now = (qsize != 0) && (head == cyc);
    pop = exp_now;
    if (obs !== 1'b0 || exp_now) begin
      checks++;
      assert (obs === exp_now) else begin
        errors++;
        $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp_now);
      end
    end
  endtask

  always @(negedge clk) begin
    bit p;
    if (mon_en) begin
      mon_one("rx_tick", bus.rx_tick, q_rx.size(), (q_rx.size() != 0) ? q_rx[0] : -1, p);
      if (p) void'(q_rx.pop_front());
      mon_one("rx_bit", bus.rx_bit, q_bit.size(), (q_bit.size() != 0) ? q_bit[0] : -1, p);
      if (p) void'(q_bit.pop_front());
      mon_one("tx_tick", bus.tx_tick, q_tx.size(), (q_tx.size() != 0) ? q_tx[0] : -1, p);
      if (p) void'(q_tx.pop_front());
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_series(input int kind, input int first, input int step, input int count);
    for (int i = 0; i < count; i++) begin
      case (kind)
        0:       q_rx.push_back(first + i * step);
        1:       q_bit.push_back(first + i * step);
        default: q_tx.push_back(first + i * step);
      endcase
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rx_q"},  q_rx.size(),  0);
    check({tag, "_bit_q"}, q_bit.size(), 0);
    check({tag, "_tx_q"},  q_tx.size(),  0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, c3, c_dis;

    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.baud_select = 3'd0;
    bus.rx_resync   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_tick", bus.rx_tick, 0);
    check("rst_rx_bit",  bus.rx_bit,  0);
    check("rst_tx_tick", bus.tx_tick, 0);
    check("rst_sel",     bus.sel_active, 0);

    // Rate code loads while disabled, then enable at sel=3 (DIV=12).
    bus.baud_select = 3'd3;
    reset           = 1'b0;
    @(posedge clk);
    #1;
    check("sel_load_disabled", bus.sel_active, 3);

    c0 = cyc;
    mon_en = 1'b1;
    push_series(0, c0 + 12, 12, 68);
    q_rx.push_back(c0 + 1200);
    q_rx.push_back(c0 + 1584);
    q_bit.push_back(c0 + 96);
    q_bit.push_back(c0 + 288);
    q_bit.push_back(c0 + 516);
    q_bit.push_back(c0 + 804);
    push_series(2, c0 + 192, 192, 4);
    bus.enable = 1'b1;

    // Resync on tick 35 (rx phase 2): next rx_bit 96 cycles later.
    wait_cyc(c0 + 419);
    bus.rx_resync = 1'b1;
    wait_cyc(c0 + 420);
    bus.rx_resync = 1'b0;

    // Resync coincident with the rx_bit due on tick 59.
    wait_cyc(c0 + 707);
    bus.rx_resync = 1'b1;
    wait_cyc(c0 + 708);
    bus.rx_resync = 1'b0;
    check("resync_bit_suppressed", bus.rx_bit, 0);
    check("resync_tick_kept", bus.rx_tick, 1);

    // Rate change 5 cycles after the tick at c0+804 takes effect at the reload.
    wait_cyc(c0 + 809);
    bus.baud_select = 3'd0;
    wait_cyc(c0 + 815);
    check("sel_before_reload", bus.sel_active, 3);
    wait_cyc(c0 + 816);
    check("sel_at_reload", bus.sel_active, 0);

    // Mid-period reset with enable dropped: strobes must stay quiet.
    wait_cyc(c0 + 1600);
    check_drained("phase_a");
    reset      = 1'b1;
    bus.enable = 1'b0;
    #1;
    check("midreset_sel", bus.sel_active, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.baud_select = 3'd7;
    c_dis           = cyc;
    wait_cyc(c_dis + 50);
    check("sel_load_disabled_7", bus.sel_active, 7);

    // DIV=1: rx_tick every cycle, tx_tick every 16, rx_bit at phase 7.
    c1 = cyc;
    push_series(0, c1 + 1, 1, 63);
    push_series(1, c1 + 8, 16, 4);
    push_series(2, c1 + 16, 16, 3);
    bus.enable = 1'b1;
    wait_cyc(c1 + 64);
    check_drained("phase_d");
    check("fast_rx_tick", bus.rx_tick, 1);
    check("fast_tx_tick", bus.tx_tick, 1);

    // Asynchronous reset clears strobes between clock edges.
    reset      = 1'b1;
    bus.enable = 1'b0;
    #1;
    check("async_rx_tick", bus.rx_tick, 0);
    check("async_tx_tick", bus.tx_tick, 0);
    check("async_rx_bit",  bus.rx_bit,  0);
    check("async_sel",     bus.sel_active, 0);
    bus.baud_select = 3'd2;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("sel_load_disabled_2", bus.sel_active, 2);

    // DIV=24 run, then reset mid-period with enable still high.
    c2 = cyc;
    push_series(0, c2 + 24, 24, 5);
    bus.enable = 1'b1;
    wait_cyc(c2 + 130);
    check_drained("phase_e");
    reset = 1'b1;
    #1;
    check("reset_enabled_sel", bus.sel_active, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    c3 = cyc;
    push_series(0, c3 + 384, 1, 1);
    push_series(0, c3 + 408, 24, 2);
    wait_cyc(c3 + 383);
    check("restart_sel_hold", bus.sel_active, 0);
    wait_cyc(c3 + 384);
    check("restart_sel_reload", bus.sel_active, 2);
    wait_cyc(c3 + 440);
    check_drained("phase_f");
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: rx_tick pulses per bit; even, >= 4.
REQ-003 SHALL have parameter CNT_W, default 16: divider counter width.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1: run/hold control for all counters.
REQ-007 SHALL have port baud_select, input, 3: rate code 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-008 SHALL have port rx_resync, input, 1: single-cycle pulse on detected start-bit edge.
REQ-009 SHALL have port rx_tick, output, 1: one-cycle oversample strobe.
REQ-010 SHALL have port rx_bit, output, 1: one-cycle bit-centre strobe for the receiver.
REQ-011 SHALL have port tx_tick, output, 1: one-cycle bit-period strobe for the transmitter.
REQ-012 SHALL have port sel_active, output, 3: rate code currently in use.

Function
REQ-013 SHALL compute DIV[s] = round(CLK_HZ / (BAUD[s] * OVERSAMPLE)) at elaboration; elaboration SHALL fail if any DIV is < 1 or >= 2**CNT_W.
REQ-014 Divider: div_cnt SHALL count down from DIV-1 to 0; at 0 with enable high, rx_tick = 1 for that cycle and div_cnt reloads DIV[sel_active]-1.
REQ-015 First rx_tick SHALL occur exactly DIV clocks after the first cycle enable is sampled high; DIV=1 gives rx_tick every enabled cycle.
REQ-016 enable low SHALL hold div_cnt at DIV[sel_active]-1, both phase counters at 0, and all strobes at 0.
REQ-017 tx phase counter SHALL increment mod OVERSAMPLE on each rx_tick; tx_tick = 1 on the rx_tick where it equals OVERSAMPLE-1.
REQ-018 rx phase counter SHALL increment mod OVERSAMPLE on each rx_tick; rx_bit = 1 on the rx_tick where it equals OVERSAMPLE/2-1.
REQ-019 rx_resync SHALL clear the rx phase counter to 0 and suppress rx_bit that cycle; div_cnt, the tx phase counter, rx_tick and tx_tick SHALL be unaffected.
REQ-020 baud_select changes while enabled SHALL take effect at the next div_cnt reload; sel_active updates in the same cycle, so no shortened or glitched period occurs.
REQ-021 baud_select changes while disabled SHALL load into sel_active on the next clock.
REQ-022 All outputs SHALL be registered or derived only from registered state; strobes are never asserted for more than one consecutive cycle unless DIV = 1.

Reset
REQ-023 reset SHALL force div_cnt = DIV[0]-1, phase counters = 0, sel_active = 0, and rx_tick = rx_bit = tx_tick = 0, immediately and independent of clk.
REQ-024 Reset deasserted mid-period SHALL restart timing exactly as after power-up (REQ-015).

Structure
REQ-025 Package baud_pkg SHALL hold the BAUD rate table, the DIV rounding function, and the rate-code constants.
REQ-026 Sub-module baud_phase_cnt (mod-OVERSAMPLE counter with clear, advance and match-strobe output) SHALL be instantiated twice, for tx and rx.

Verification (CLK_HZ=1_843_200, OVERSAMPLE=16, so DIV = 384, 96, 24, 12, 6, 3, 2, 1)
REQ-027 Reset, then enable=1, sel=3 -> first rx_tick at cycle 12, then every 12 cycles; first tx_tick at cycle 192, then every 192; first rx_bit at cycle 96.
REQ-028 sel=7 -> rx_tick high every cycle; tx_tick every 16 cycles.
REQ-029 sel changes 3 -> 0 five cycles after an rx_tick -> next rx_tick 7 cycles later, then 384-cycle spacing; sel_active = 0 at that reload.
REQ-030 rx_resync at arbitrary phase, sel=3 -> rx_bit exactly 8*12 = 96 cycles later; tx_tick spacing unchanged at 192.
REQ-031 rx_resync coincident with an rx_bit cycle -> rx_bit = 0 that cycle, next rx_bit 96 cycles later.
REQ-032 reset asserted mid-period, then enable dropped for 50 cycles -> strobes stay 0 throughout; timing restarts per REQ-015 on re-enable.
